// File: rtl/ping_capture_sequencer_if.sv
// Handshake and data bundle between the ping sequencer, the per-channel estimators,
// the triangulation solver and the position consumer.
interface ping_capture_sequencer_if #(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 8
);
    logic            arm;
    logic [N-1:0]    hit_valid;
    logic [N*DW-1:0] hit_dist;
    logic            solve_start;
    logic [N*DW-1:0] solve_dist;
    logic            solve_done;
    logic [8:0]      solve_pos;
    logic            pos_valid;
    logic            pos_ready;
    logic [8:0]      pos;
    logic [N-1:0]    hit_mask;
    logic            busy;
    logic            timeout_err;

    // Sequencer side.
    modport slave (
        input  arm, hit_valid, hit_dist, solve_done, solve_pos, pos_ready,
        output solve_start, solve_dist, pos_valid, pos, hit_mask, busy, timeout_err
    );

    // Environment side: estimators, solver and consumer.
    modport master (
        output arm, hit_valid, hit_dist, solve_done, solve_pos, pos_ready,
        input  solve_start, solve_dist, pos_valid, pos, hit_mask, busy, timeout_err
    );
endinterface

// File: rtl/ping_capture_sequencer.sv
// Captures one ping's per-channel distances within a bounded window, runs the solver and
// returns its position. Define PING_SEQ_AUTO_REARM_EN to re-enter capture automatically.
module ping_capture_sequencer #(
    parameter int unsigned N      = 3,
    parameter int unsigned DW     = 8,
    parameter int unsigned WINDOW = 1023
) (
    input logic                   clk,
    input logic                   rst_n,
    ping_capture_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WinLast = CW'(WINDOW);

    typedef enum logic [2:0] {StIdle, StCapture, StSolve, StWait, StOutput} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [N*DW-1:0] dist_q, dist_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [8:0]      pos_q, pos_d;
    logic            solve_start_q, solve_start_d;
    logic            pos_valid_q, pos_valid_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic [N-1:0]    new_hits;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        dist_d    = dist_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        timeout_d = 1'b0;
        new_hits  = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.arm) begin
                    state_d = StCapture;
                    mask_d  = '0;
                    cnt_d   = '0;
                end
            end
            StCapture: begin
                new_hits = bus.hit_valid & ~mask_q;
                mask_d   = mask_q | new_hits;
                for (int unsigned i = 0; i < N; i++) begin
                    if (new_hits[i]) dist_d[i*DW +: DW] = bus.hit_dist[i*DW +: DW];
                end
                // Counter only runs once the first hit has been latched; it saturates.
                if (mask_q != '0 && cnt_q != WinLast) cnt_d = cnt_q + CW'(1);
                if (&mask_d) begin
                    state_d = StSolve;
                end else if (mask_q != '0 && cnt_d == WinLast) begin
                    timeout_d = 1'b1;
`ifdef PING_SEQ_AUTO_REARM_EN
                    state_d   = StCapture;
                    mask_d    = '0;
                    cnt_d     = '0;
`else
                    state_d   = StIdle;
`endif
                end
            end
            StSolve: state_d = StWait;
            StWait: begin
                if (bus.solve_done) begin
                    pos_d   = bus.solve_pos;
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (bus.pos_ready) begin
`ifdef PING_SEQ_AUTO_REARM_EN
                    state_d = StCapture;
                    mask_d  = '0;
                    cnt_d   = '0;
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
        solve_start_d = (state_d == StSolve);
        pos_valid_d   = (state_d == StOutput);
        busy_d        = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            mask_q        <= '0;
            dist_q        <= '0;
            cnt_q         <= '0;
            pos_q         <= '0;
            solve_start_q <= 1'b0;
            pos_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            dist_q        <= dist_d;
            cnt_q         <= cnt_d;
            pos_q         <= pos_d;
            solve_start_q <= solve_start_d;
            pos_valid_q   <= pos_valid_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.solve_start = solve_start_q;
    assign bus.solve_dist  = dist_q;
    assign bus.pos_valid   = pos_valid_q;
    assign bus.pos         = pos_q;
    assign bus.hit_mask    = mask_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_ping_capture_sequencer.sv
// Bench for ping_capture_sequencer: directed scenarios plus randomized pings checked
// against a first-hit-time model of the capture window.
module tb_ping_capture_sequencer;
    localparam int unsigned N  = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned W  = 5;
    localparam int          L  = 24;
    localparam logic [N-1:0] Full = {N{1'b1}};
`ifdef PING_SEQ_AUTO_REARM_EN
    localparam bit Rearm = 1'b1;
`else
    localparam bit Rearm = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    ping_capture_sequencer_if #(.N(N), .DW(DW)) bus ();
    ping_capture_sequencer #(.N(N), .DW(DW), .WINDOW(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hit schedule indexed by edge number after the arm edge (edge 0).
    logic [N-1:0]    sched_v [L];
    logic [N*DW-1:0] sched_d [L];
    int              m_first [N];
    logic [N*DW-1:0] m_dist;
    bit              m_solved;
    int              m_end;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.arm = 1'b0; bus.hit_valid = '0; bus.hit_dist = '0;
        bus.solve_done = 1'b0; bus.solve_pos = '0; bus.pos_ready = 1'b0;
    endtask

    task automatic clear_sched();
        for (int c = 0; c < L; c++) begin
            sched_v[c] = '0;
            sched_d[c] = (N*DW)'({$urandom, $urandom});
        end
    endtask

    task automatic add_hit(input int c, input int ch, input logic [DW-1:0] val);
        sched_v[c][ch] = 1'b1;
        sched_d[c][ch*DW +: DW] = val;
    endtask

    // Outcome from each channel's first hit time: solved if the spread fits the window.
    task automatic model();
        int tf, tc;
        bit all;
        tf = L; tc = 0; all = 1'b1; m_dist = '0;
        for (int i = 0; i < int'(N); i++) m_first[i] = -1;
        for (int c = 1; c < L; c++)
            for (int i = 0; i < int'(N); i++)
                if (sched_v[c][i] && m_first[i] < 0) begin
                    m_first[i] = c;
                    m_dist[i*DW +: DW] = sched_d[c][i*DW +: DW];
                end
        for (int i = 0; i < int'(N); i++) begin
            if (m_first[i] < 0) all = 1'b0;
            else begin
                if (m_first[i] < tf) tf = m_first[i];
                if (m_first[i] > tc) tc = m_first[i];
            end
        end
        m_solved = all && (tc - tf <= int'(W));
        m_end    = m_solved ? tc : tf + int'(W);
    endtask

    function automatic logic [N-1:0] exp_mask(input int c);
        exp_mask = '0;
        for (int i = 0; i < int'(N); i++)
            if (m_first[i] >= 1 && m_first[i] <= c) exp_mask[i] = 1'b1;
    endfunction

    task automatic run_ping(input bit do_arm, input int wait_c, input int bp_c,
                            input logic [8:0] p, input bit rst_wait);
        logic [N+3:0] got, exp;
        model();
        if (do_arm) begin
            bus.arm = 1'b1;
            step();
            bus.arm = 1'b0;
            n_vec++;
            if (bus.busy !== 1'b1 || bus.hit_mask !== '0) begin
                $display("FAIL arm busy/mask got %b/%b want 1/0", bus.busy, bus.hit_mask);
                n_err++;
            end
        end
        for (int c = 1; c <= m_end; c++) begin
            bus.hit_valid = sched_v[c]; bus.hit_dist = sched_d[c];
            bus.arm = 1'($urandom); bus.solve_done = 1'($urandom);
            bus.solve_pos = 9'($urandom); bus.pos_ready = 1'($urandom);
            step();
            if (c < m_end) exp = {1'b1, 1'b0, 1'b0, 1'b0, exp_mask(c)};
            else if (m_solved) exp = {1'b1, 1'b1, 1'b0, 1'b0, Full};
            else exp = {Rearm, 1'b0, 1'b1, 1'b0, Rearm ? {N{1'b0}} : exp_mask(c)};
            got = {bus.busy, bus.solve_start, bus.timeout_err, bus.pos_valid, bus.hit_mask};
            n_vec++;
            if (got !== exp) begin
                $display("FAIL capture c=%0d {busy,start,tmo,pv,mask} got %b want %b", c, got, exp);
                n_err++;
            end
        end
        idle_inputs();
        if (!m_solved) begin
            step();
            n_vec++;
            if (bus.timeout_err !== 1'b0 || bus.busy !== Rearm) begin
                $display("FAIL post_timeout tmo/busy got %b/%b want 0/%b",
                         bus.timeout_err, bus.busy, Rearm);
                n_err++;
            end
            return;
        end
        n_vec++;
        if (bus.solve_dist !== m_dist) begin
            $display("FAIL solve_dist got %h want %h", bus.solve_dist, m_dist);
            n_err++;
        end
        step();
        n_vec++;
        if ({bus.busy, bus.solve_start, bus.pos_valid} !== 3'b100 || bus.solve_dist !== m_dist) begin
            $display("FAIL wait_entry {busy,start,pv} got %b want 100 dist %h want %h",
                     {bus.busy, bus.solve_start, bus.pos_valid}, bus.solve_dist, m_dist);
            n_err++;
        end
        if (rst_wait) begin
            rst_n = 1'b0; bus.arm = 1'b1;
            step();
            rst_n = 1'b1; bus.arm = 1'b0;
            n_vec++;
            if ({bus.solve_start, bus.pos_valid, bus.timeout_err, bus.busy, bus.pos,
                 bus.hit_mask, bus.solve_dist} !== '0) begin
                $display("FAIL reset_in_wait outputs got pv=%b busy=%b pos=%h mask=%b dist=%h want 0",
                         bus.pos_valid, bus.busy, bus.pos, bus.hit_mask, bus.solve_dist);
                n_err++;
            end
            bus.solve_done = 1'b1; bus.solve_pos = 9'h155;
            step();
            bus.solve_done = 1'b0;
            n_vec++;
            if ({bus.pos_valid, bus.busy, bus.pos} !== '0) begin
                $display("FAIL late_solve_done pv/busy/pos got %b/%b/%h want 0/0/0",
                         bus.pos_valid, bus.busy, bus.pos);
                n_err++;
            end
            return;
        end
        repeat (wait_c) begin
            bus.arm = 1'($urandom); bus.pos_ready = 1'($urandom);
            step();
            n_vec++;
            if (bus.pos_valid !== 1'b0 || bus.busy !== 1'b1) begin
                $display("FAIL wait pv/busy got %b/%b want 0/1", bus.pos_valid, bus.busy);
                n_err++;
            end
        end
        bus.arm = 1'b0; bus.pos_ready = 1'b0; bus.solve_done = 1'b1; bus.solve_pos = p;
        step();
        bus.solve_done = 1'b0;
        n_vec++;
        if ({bus.pos_valid, bus.busy, bus.pos} !== {2'b11, p}) begin
            $display("FAIL result pv/busy/pos got %b/%b/%h want 1/1/%h",
                     bus.pos_valid, bus.busy, bus.pos, p);
            n_err++;
        end
        repeat (bp_c) begin
            bus.arm = 1'($urandom); bus.solve_done = 1'($urandom); bus.solve_pos = ~p;
            step();
            n_vec++;
            if ({bus.pos_valid, bus.busy, bus.pos} !== {2'b11, p}) begin
                $display("FAIL backpressure pv/busy/pos got %b/%b/%h want 1/1/%h",
                         bus.pos_valid, bus.busy, bus.pos, p);
                n_err++;
            end
        end
        idle_inputs();
        bus.pos_ready = 1'b1;
        step();
        bus.pos_ready = 1'b0;
        n_vec++;
        if ({bus.pos_valid, bus.busy, bus.solve_start} !== {1'b0, Rearm, 1'b0}) begin
            $display("FAIL transfer {pv,busy,start} got %b want %b",
                     {bus.pos_valid, bus.busy, bus.solve_start}, {1'b0, Rearm, 1'b0});
            n_err++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.arm = 1'b1; bus.hit_valid = Full; bus.solve_done = 1'b1; bus.pos_ready = 1'b1;
        step(); step();
        idle_inputs();
        rst_n = 1'b1;
        n_vec++;
        if ({bus.solve_start, bus.pos_valid, bus.timeout_err, bus.busy, bus.pos,
             bus.hit_mask, bus.solve_dist} !== '0) begin
            $display("FAIL reset outputs got pv=%b busy=%b pos=%h mask=%b dist=%h want 0",
                     bus.pos_valid, bus.busy, bus.pos, bus.hit_mask, bus.solve_dist);
            n_err++;
        end
    endtask

    task automatic test_normal_ping();
        clear_sched();
        add_hit(2, 0, 8'd10); add_hit(5, 1, 8'd20); add_hit(7, 2, 8'd30);
        run_ping(1'b1, 2, 0, 9'h1A5, 1'b0);
        n_vec++;
        if (bus.solve_dist !== {8'd30, 8'd20, 8'd10}) begin
            $display("FAIL normal_dist got %h want 1e140a", bus.solve_dist);
            n_err++;
        end
    endtask

    task automatic test_simultaneous();
        clear_sched();
        add_hit(1, 0, 8'd5); add_hit(1, 2, 8'd7); add_hit(2, 0, 8'd99); add_hit(2, 1, 8'd3);
        run_ping(1'b1, 0, 0, 9'h0C3, 1'b0);
        n_vec++;
        if (bus.solve_dist !== {8'd7, 8'd3, 8'd5}) begin
            $display("FAIL simultaneous_dist got %h want 070305", bus.solve_dist);
            n_err++;
        end
    endtask

    task automatic test_timeout();
        clear_sched();
        add_hit(1, 0, 8'd40); add_hit(3, 1, 8'd41);
        run_ping(1'b1, 0, 0, 9'h000, 1'b0);
`ifndef PING_SEQ_AUTO_REARM_EN
        bus.hit_valid = 3'b100; bus.hit_dist = {8'd42, 16'h0};
        step();
        idle_inputs();
        n_vec++;
        if ({bus.hit_mask, bus.busy} !== {3'b011, 1'b0}) begin
            $display("FAIL late_hit mask/busy got %b/%b want 011/0", bus.hit_mask, bus.busy);
            n_err++;
        end
`endif
    endtask

    task automatic test_window_edge();
        clear_sched();
        add_hit(1, 0, 8'd1); add_hit(2, 1, 8'd2); add_hit(1 + int'(W), 2, 8'd3);
        run_ping(1'b1, 1, 0, 9'h03C, 1'b0);
    endtask

    task automatic test_backpressure();
        clear_sched();
        add_hit(1, 1, DW'($urandom)); add_hit(3, 0, DW'($urandom)); add_hit(4, 2, DW'($urandom));
        run_ping(1'b1, 1, 10, 9'h0F3, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            clear_sched();
            for (int i = 0; i < int'(N); i++)
                if (i == 0 || $urandom_range(9) != 0)
                    add_hit(int'($urandom_range(1, 12)), i, DW'($urandom));
            repeat ($urandom_range(3))
                add_hit(int'($urandom_range(1, L - 1)), int'($urandom_range(N - 1)), DW'($urandom));
            run_ping(1'b1, int'($urandom_range(3)), int'($urandom_range(4)), 9'($urandom), 1'b0);
        end
    endtask

    task automatic test_reset_in_wait();
        clear_sched();
        add_hit(1, 0, 8'd11); add_hit(1, 1, 8'd22); add_hit(2, 2, 8'd33);
        run_ping(1'b1, 0, 0, 9'h000, 1'b1);
    endtask

    task automatic test_auto_rearm();
`ifdef PING_SEQ_AUTO_REARM_EN
        clear_sched();
        add_hit(1, 0, 8'd70); add_hit(2, 1, 8'd71); add_hit(3, 2, 8'd72);
        run_ping(1'b1, 0, 0, 9'h0AA, 1'b0);
        clear_sched();
        add_hit(2, 2, 8'd80); add_hit(2, 0, 8'd81); add_hit(4, 1, 8'd82);
        run_ping(1'b0, 1, 2, 9'h155, 1'b0);
`else
        bus.hit_valid = Full; bus.hit_dist = 24'hABCDEF;
        step();
        idle_inputs();
        n_vec++;
        if ({bus.busy, bus.hit_mask, bus.solve_start} !== '0) begin
            $display("FAIL no_arm busy/mask/start got %b/%b/%b want 0/000/0",
                     bus.busy, bus.hit_mask, bus.solve_start);
            n_err++;
        end
`endif
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_normal_ping();
        test_simultaneous();
        test_timeout();
        test_window_edge();
        test_backpressure();
        test_random();
        test_reset_in_wait();
        test_auto_rearm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
